// File: rtl/jesd204b_tpl_rx_deframer.sv
// rtl/jesd204b_tpl_rx_deframer.sv - JESD204B receive transport-layer deframer with multiframe tracking and 2-entry output FIFO
module jesd204b_tpl_rx_deframer #(
  parameter int LANES       = 4,
  parameter int CONVERTERS  = 8,
  parameter int RESOLUTION  = 11,
  parameter int CONTROL     = 2,
  parameter int SAMPLE_SIZE = 16,
  parameter int SAMPLES     = 1,
  parameter int K_FRAMES    = 32,
  localparam int MP = ((CONVERTERS + LANES - 1) / LANES) * LANES,
  localparam int FW = SAMPLES * SAMPLE_SIZE * MP,
  localparam int DW = SAMPLES * CONVERTERS * RESOLUTION,
  localparam int CW = (CONTROL > 0) ? SAMPLES * CONVERTERS * CONTROL : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic          in_somf,
  input  logic [FW-1:0] rx_datain,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] rx_dataout,
  output logic [CW-1:0] rx_ctrlout,
  output logic          out_somf,
  output logic [4:0]    frame_cnt,
  output logic          tail_err,
  output logic          align_err,
  output logic          overflow
);

  localparam int NSLOT = CONVERTERS * SAMPLES;
  localparam int UW    = NSLOT * SAMPLE_SIZE;
  localparam int TW    = SAMPLE_SIZE - RESOLUTION - CONTROL;
  localparam int EW    = DW + CW + 6;
  localparam logic [4:0] LAST_IDX = 5'(K_FRAMES - 1);

  logic          s1_valid_q;
  logic          s1_somf_q;
  logic [UW-1:0] s1_frame_q;

  logic [DW-1:0]    unp_data;
  logic [CW-1:0]    unp_ctrl;
  logic [NSLOT-1:0] slot_tail;

  logic [4:0]    cnt_q, cnt_d;
  logic          started_q, started_d;
  logic [4:0]    exp_idx, cur_idx;
  logic          tail_d, align_d;
  logic [EW-1:0] entry_d;

  logic          s2_valid_q;
  logic [EW-1:0] s2_entry_q;
  logic          tail_err_q, align_err_q;

  logic [EW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop, push;
  logic [EW-1:0] head;

  // Padding slots beyond M*S never reach the unpacker.
  if (UW < FW) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rx_datain[FW-1:UW];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_somf_q  <= 1'b0;
      s1_frame_q <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_somf_q  <= in_valid & in_somf;
      if (in_valid) s1_frame_q <= rx_datain[UW-1:0];
    end
  end

  for (genvar j = 0; j < NSLOT; j++) begin : g_slot
    logic [SAMPLE_SIZE-1:0] slot;
    assign slot = s1_frame_q[j*SAMPLE_SIZE +: SAMPLE_SIZE];
    assign unp_data[j*RESOLUTION +: RESOLUTION] = slot[SAMPLE_SIZE-1 -: RESOLUTION];
    if (CONTROL > 0) begin : g_ctrl
      assign unp_ctrl[j*CONTROL +: CONTROL] = slot[SAMPLE_SIZE-1-RESOLUTION -: CONTROL];
    end
    if (TW > 0) begin : g_tail
      assign slot_tail[j] = |slot[TW-1:0];
    end else begin : g_notail
      assign slot_tail[j] = 1'b0;
    end
  end

  if (CONTROL == 0) begin : g_noctrl
    assign unp_ctrl = 1'b0;
  end

  // An in_somf frame always resyncs the index; the error only flags an unexpected resync.
  always_comb begin
    exp_idx = 5'd0;
    if (started_q) exp_idx = (cnt_q == LAST_IDX) ? 5'd0 : cnt_q + 5'd1;
    cur_idx   = s1_somf_q ? 5'd0 : exp_idx;
    align_d   = s1_valid_q & s1_somf_q & (exp_idx != 5'd0);
    tail_d    = s1_valid_q & (|slot_tail);
    cnt_d     = s1_valid_q ? cur_idx : cnt_q;
    started_d = started_q | s1_valid_q;
    entry_d   = {(cur_idx == 5'd0), cur_idx, unp_ctrl, unp_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q  <= 1'b0;
      s2_entry_q  <= '0;
      tail_err_q  <= 1'b0;
      align_err_q <= 1'b0;
      cnt_q       <= 5'd0;
      started_q   <= 1'b0;
    end else begin
      s2_valid_q  <= s1_valid_q;
      if (s1_valid_q) s2_entry_q <= entry_d;
      tail_err_q  <= tail_d;
      align_err_q <= align_d;
      cnt_q       <= cnt_d;
      started_q   <= started_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop        = (count_q != 2'd0) & out_ready;
    push       = s2_valid_q & ((count_q != 2'd2) | pop);
    overflow_d = overflow_q | (s2_valid_q & (count_q == 2'd2) & ~pop);
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= s2_entry_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != 2'd0);
  assign rx_dataout = head[DW-1:0];
  assign rx_ctrlout = head[DW +: CW];
  assign frame_cnt  = head[DW+CW +: 5];
  assign out_somf   = head[EW-1];
  assign tail_err   = tail_err_q;
  assign align_err  = align_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_jesd204b_tpl_rx_deframer.sv
// tb/tb_jesd204b_tpl_rx_deframer.sv - randomized bench with frame-level reference model for two deframer configurations
module tb_jesd204b_tpl_rx_deframer;

  localparam int K = 32;

  typedef struct {
    int         cap;
    logic [127:0] data;
    logic [127:0] ctrl;
    bit         somf;
    int         idx;
    bit         tail;
    bit         align;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_somf = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] rx_datain = '0;

  logic        ov0, os0, te0, ae0, of0;
  logic [87:0] od0;
  logic [15:0] oc0;
  logic [4:0]  fc0;
  logic        ov1, os1, te1, ae1, of1;
  logic [71:0] od1;
  logic [0:0]  oc1;
  logic [4:0]  fc1;

  always #5 clk = ~clk;

  jesd204b_tpl_rx_deframer u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_somf(in_somf),
    .rx_datain(rx_datain), .out_valid(ov0), .out_ready(out_ready),
    .rx_dataout(od0), .rx_ctrlout(oc0), .out_somf(os0), .frame_cnt(fc0),
    .tail_err(te0), .align_err(ae0), .overflow(of0)
  );

  jesd204b_tpl_rx_deframer #(
    .LANES(2), .CONVERTERS(3), .RESOLUTION(12), .CONTROL(0),
    .SAMPLE_SIZE(16), .SAMPLES(2), .K_FRAMES(32)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_somf(in_somf),
    .rx_datain(rx_datain), .out_valid(ov1), .out_ready(out_ready),
    .rx_dataout(od1), .rx_ctrlout(oc1), .out_somf(os1), .frame_cnt(fc1),
    .tail_err(te1), .align_err(ae1), .overflow(of1)
  );

  int cfg_m [2] = '{8, 3};
  int cfg_s [2] = '{1, 2};
  int cfg_n [2] = '{11, 12};
  int cfg_cs[2] = '{2, 0};

  ent_t mq[2][$];
  ent_t pq[2][$];
  bit   started[2];
  int   prev[2];
  bit   ovf[2];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   align_cnt = 0;
  int   obs[$];

  logic [127:0] f1, f2, f3, fb;

  task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  function automatic ent_t unpack(input int k, input logic [127:0] f);
    ent_t e;
    int n, cs, tw, slot, d, c, t;
    logic [127:0] sh, tmp;
    e.cap = 0; e.data = '0; e.ctrl = '0; e.somf = 0; e.idx = 0; e.tail = 0; e.align = 0;
    n = cfg_n[k]; cs = cfg_cs[k]; tw = 16 - n - cs;
    for (int j = 0; j < cfg_m[k] * cfg_s[k]; j++) begin
      sh   = f >> (j * 16);
      slot = int'(sh[15:0]);
      d    = slot >> (16 - n);
      c    = (slot >> tw) & ((1 << cs) - 1);
      t    = slot & ((1 << tw) - 1);
      tmp  = 128'(d);
      e.data |= tmp << (j * n);
      tmp  = 128'(c);
      e.ctrl |= tmp << (j * cs);
      if (t != 0) e.tail = 1;
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      pq[k].delete();
      started[k] = 0;
      prev[k] = 0;
      ovf[k] = 0;
    end
  endtask

  // Frame captured at edge c: flags visible after c+1, enters the sink queue at c+2.
  task automatic model_edge(input int k);
    ent_t e;
    int expn;
    if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
    if (pq[k].size() > 0 && pq[k][0].cap == cyc - 2) begin
      e = pq[k].pop_front();
      if (mq[k].size() < 2) mq[k].push_back(e);
      else ovf[k] = 1;
    end
    if (in_valid) begin
      e = unpack(k, rx_datain);
      expn = started[k] ? (prev[k] + 1) % K : 0;
      e.idx = in_somf ? 0 : expn;
      e.align = in_somf && (expn != 0);
      e.somf = (e.idx == 0);
      e.cap = cyc;
      started[k] = 1;
      prev[k] = e.idx;
      pq[k].push_back(e);
    end
  endtask

  task automatic compare(input int k);
    bit av, as, at, aa, ao, ev, et, ea;
    logic [127:0] ad, ac;
    logic [4:0] af;
    if (k == 0) begin
      av = ov0; ad = 128'(od0); ac = 128'(oc0); as = os0; af = fc0; at = te0; aa = ae0; ao = of0;
    end else begin
      av = ov1; ad = 128'(od1); ac = 128'(oc1); as = os1; af = fc1; at = te1; aa = ae1; ao = of1;
    end
    ev = (mq[k].size() > 0);
    chk("out_valid", k, 128'(av), 128'(ev));
    if (ev && av) begin
      chk("rx_dataout", k, ad, mq[k][0].data);
      chk("rx_ctrlout", k, ac, mq[k][0].ctrl);
      chk("out_somf", k, 128'(as), 128'(mq[k][0].somf));
      chk("frame_cnt", k, 128'(af), 128'(mq[k][0].idx));
    end
    et = 0; ea = 0;
    for (int i = 0; i < pq[k].size(); i++) begin
      if (pq[k][i].cap == cyc - 1) begin
        et = pq[k][i].tail;
        ea = pq[k][i].align;
      end
    end
    chk("tail_err", k, 128'(at), 128'(et));
    chk("align_err", k, 128'(aa), 128'(ea));
    chk("overflow", k, 128'(ao), 128'(ovf[k]));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) begin
      cyc++;
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
    compare(0);
    compare(1);
    if (ae0) align_cnt++;
    if (ov0) obs.push_back(int'(fc0));
  endtask

  task automatic drive(input bit v, input bit s, input logic [127:0] f);
    in_valid = v; in_somf = s; rx_datain = f;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_somf = 0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset_n = 0;
    in_valid = 0; in_somf = 0;
    model_clear();
    obs.delete();
    step();
    reset_n = 1;
  endtask

  function automatic logic [127:0] rand_frame();
    logic [127:0] f;
    int mode;
    f = {$urandom, $urandom, $urandom, $urandom};
    mode = $urandom_range(0, 2);
    for (int j = 0; j < 8; j++) begin
      if (mode == 1) f[j*16 +: 3] = 3'b000;
      else if (mode == 2) f[j*16 +: 4] = 4'b0000;
    end
    return f;
  endfunction

  initial begin
    f1 = 128'he360c360_cb60d360_e760c760_cf60d760;
    f2 = f1; f2[15:0] = 16'hd761;
    f3 = f1; f3[127:112] = 16'he36f;
    fb = 128'h0020;
    model_clear();
    step(); step();
    chk("rst_out_valid", 0, 128'(ov0), 128'd0);
    chk("rst_dataout", 0, 128'(od0), 128'd0);
    chk("rst_frame_cnt", 0, 128'(fc0), 128'd0);
    chk("rst_overflow", 0, 128'(of0), 128'd0);
    chk("rst_out_valid", 1, 128'(ov1), 128'd0);
    reset_n = 1;
    out_ready = 1;

    drive(1, 1, f1);
    idle(1);
    chk("t1_tail", 0, 128'(te0), 128'd0);
    idle(1);
    chk("t1_valid", 0, 128'(ov0), 128'd1);
    chk("t1_conv0", 0, 128'(od0[10:0]), 128'h6BB);
    chk("t1_conv7", 0, 128'(od0[87:77]), 128'h71B);
    chk("t1_ctrl", 0, 128'(oc0), 128'd0);
    chk("t1_somf", 0, 128'(os0), 128'd1);
    chk("t1_fcnt", 0, 128'(fc0), 128'd0);
    chk("t1_s0", 1, 128'(od1[11:0]), 128'hD76);
    chk("t1_s5", 1, 128'(od1[71:60]), 128'hCB6);
    idle(1);

    drive(1, 0, f2);
    idle(1);
    chk("t2_tail", 0, 128'(te0), 128'd1);
    chk("t2_tail", 1, 128'(te1), 128'd1);
    idle(1);
    chk("t2_conv0", 0, 128'(od0[10:0]), 128'h6BB);
    chk("t2_s0", 1, 128'(od1[11:0]), 128'hD76);

    drive(1, 0, f3);
    idle(1);
    chk("t2b_tail", 0, 128'(te0), 128'd1);
    chk("t2b_pad_tail", 1, 128'(te1), 128'd0);
    idle(1);
    chk("t2b_ctrl7", 0, 128'(oc0[15:14]), 128'd1);
    chk("t2b_conv7", 0, 128'(od0[87:77]), 128'h71B);
    idle(2);

    do_reset();
    align_cnt = 0;
    for (int i = 0; i < 40; i++) drive(1, (i == 0) || (i == 32), rand_frame());
    idle(3);
    chk("t3_align_cnt", 0, 128'(align_cnt), 128'd0);
    chk("t3_frames", 0, 128'(obs.size()), 128'd40);
    chk("t3_idx31", 0, 128'(obs[31]), 128'd31);
    chk("t3_idx32", 0, 128'(obs[32]), 128'd0);
    chk("t3_idx39", 0, 128'(obs[39]), 128'd7);

    do_reset();
    align_cnt = 0;
    for (int i = 0; i < 40; i++) drive(1, (i == 0) || (i == 19), rand_frame());
    idle(3);
    chk("t3b_align_cnt", 0, 128'(align_cnt), 128'd1);
    chk("t3b_idx18", 0, 128'(obs[18]), 128'd18);
    chk("t3b_idx19", 0, 128'(obs[19]), 128'd0);
    chk("t3b_idx39", 0, 128'(obs[39]), 128'd20);

    chk("t4_pre_ovf", 0, 128'(of0), 128'd0);
    out_ready = 0;
    drive(1, 0, f1);
    drive(1, 0, fb);
    drive(1, 0, f3);
    idle(3);
    chk("t4_ovf", 0, 128'(of0), 128'd1);
    chk("t4_valid", 0, 128'(ov0), 128'd1);
    chk("t4_head0", 0, 128'(od0[10:0]), 128'h6BB);
    out_ready = 1;
    idle(1);
    chk("t4_head1", 0, 128'(od0[10:0]), 128'h001);
    chk("t4_valid1", 0, 128'(ov0), 128'd1);
    idle(1);
    chk("t4_empty", 0, 128'(ov0), 128'd0);

    do_reset();
    out_ready = 0;
    drive(1, 1, f1);
    drive(1, 0, fb);
    idle(2);
    out_ready = 1;
    for (int i = 0; i < 6; i++) drive(1, 0, rand_frame());
    idle(4);
    chk("t5_no_ovf", 0, 128'(of0), 128'd0);
    chk("t5_no_ovf", 1, 128'(of1), 128'd0);

    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rand_frame());
    end
    #2;
    reset_n = 0;
    model_clear();
    #1;
    chk("async_valid", 0, 128'(ov0), 128'd0);
    chk("async_data", 0, 128'(od0), 128'd0);
    chk("async_ctrl", 0, 128'(oc0), 128'd0);
    chk("async_somf", 0, 128'(os0), 128'd0);
    chk("async_fcnt", 0, 128'(fc0), 128'd0);
    chk("async_ovf", 0, 128'(of0), 128'd0);
    chk("async_flags", 0, 128'({te0, ae0}), 128'd0);
    chk("async_valid", 1, 128'(ov1), 128'd0);
    chk("async_ovf", 1, 128'(of1), 128'd0);
    step();
    reset_n = 1;
    for (int i = 0; i < 200; i++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rand_frame());
    end
    out_ready = 1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
